usb_pio_out: RTL and testbench

Parametrised Avalon-MM output PIO for the USB/LED subsystem. It generalises the single-bit output register to WIDTH bits and adds atomic set, clear and toggle writes. An optional hardware blink timer toggles selected bits every BLINK_PERIOD clocks with no CPU involvement. It sits on the Avalon-MM interconnect as a zero-wait-state slave and drives LED, USB-control or strap pins through out_port.

---
 rtl/usb_pio_pkg.sv | 14 +
 rtl/usb_pio_out_if.sv | 21 ++
 rtl/usb_pio_blink_timer.sv | 50 +++++
 rtl/usb_pio_out.sv | 108 ++++++++++
 tb/tb_usb_pio_out.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pio_pkg.sv
// Shared constants for the USB/LED output PIO: register word addresses and bus geometry.
package usb_pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET          = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR        = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE       = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 3'd5;

endpackage

// File: rtl/usb_pio_out_if.sv
// Avalon-MM slave bus bundle for usb_pio_out (zero wait states, combinational readdata).
interface usb_pio_out_if;
    import usb_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/usb_pio_blink_timer.sv
// Blink down-counter: holds the period register and pulses tick every `period` clocks.
// Only instantiated when USB_PIO_BLINK_EN is defined.
module usb_pio_blink_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period_i,
    input  logic             load_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] period_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A period of zero disables the timer entirely.
    assign tick_o   = (period_q != '0) && (cnt_q == '0);
    assign period_o = period_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            period_d = period_i;
            cnt_d    = (period_i == '0) ? '0 : period_i - ONE;
        end else if (period_q == '0) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = period_q - ONE;
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_pio_out.sv
// WIDTH-bit Avalon-MM output PIO with atomic set/clear/toggle writes.
// Define USB_PIO_BLINK_EN to add the hardware blink timer (BLINK_MASK / BLINK_PERIOD).
module usb_pio_out
    import usb_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       CNT_W       = 24,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    usb_pio_out_if.slave      bus,
    output logic [WIDTH-1:0]  out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic             blink_tick;
    logic [WIDTH-1:0] blink_mask;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

`ifdef USB_PIO_BLINK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] period_val;
    logic             period_load;

    assign period_load = wr && (bus.address == ADDR_BLINK_PERIOD);

    usb_pio_blink_timer #(
        .CNT_W (CNT_W)
    ) u_blink_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .period_i (bus.writedata[CNT_W-1:0]),
        .load_i   (period_load),
        .tick_o   (blink_tick),
        .period_o (period_val)
    );

    always_comb begin
        mask_d = mask_q;
        if (wr && (bus.address == ADDR_BLINK_MASK)) begin
            mask_d = wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign blink_mask = mask_q;
`else
    localparam int unsigned UNUSED_CNT_W = CNT_W;

    assign blink_tick = 1'b0;
    assign blink_mask = '0;
`endif

    // A bus write to any data-modifying register overrides a coincident blink toggle.
    always_comb begin
        data_d = data_q;
        if (blink_tick) begin
            data_d = data_q ^ blink_mask;
        end
        if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_d = wd;
                ADDR_SET:    data_d = data_q | wd;
                ADDR_CLEAR:  data_d = data_q & ~wd;
                ADDR_TOGGLE: data_d = data_q ^ wd;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign out_port = data_q;

    // Write-only and reserved addresses read back as zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:         bus.readdata = BUS_W'(data_q);
`ifdef USB_PIO_BLINK_EN
            ADDR_BLINK_MASK:   bus.readdata = BUS_W'(mask_q);
            ADDR_BLINK_PERIOD: bus.readdata = BUS_W'(period_val);
`endif
            default:           bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_usb_pio_out.sv
// Self-checking bench for usb_pio_out: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural model (tick edges derived from write time and period).
module tb_usb_pio_out;
    import usb_pio_pkg::*;

    localparam logic [7:0] RV = 8'h5A;
`ifdef USB_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;

    usb_pio_out_if bus ();

    usb_pio_out #(
        .WIDTH       (8),
        .CNT_W       (24),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: ticks fall on edges k0+P, k0+2P, ... after a period write at edge k0.
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [23:0] m_period;
    longint      m_edge;
    longint      m_k0;

    always @(posedge clk or negedge reset_n) begin : model
        bit         wr_now;
        bit         tick_now;
        logic [7:0] nd;
        if (!reset_n) begin
            m_data   <= RV;
            m_mask   <= 8'h00;
            m_period <= 24'h0;
            m_edge   <= 0;
            m_k0     <= 0;
        end else begin
            wr_now   = bus.chipselect && !bus.write_n;
            tick_now = BLINK && (m_period != 0) && (m_edge > m_k0) &&
                       (((m_edge - m_k0) % longint'(m_period)) == 0);
            nd = tick_now ? (m_data ^ m_mask) : m_data;
            if (wr_now) begin
                case (bus.address)
                    3'd0: nd = bus.writedata[7:0];
                    3'd1: nd = m_data | bus.writedata[7:0];
                    3'd2: nd = m_data & ~bus.writedata[7:0];
                    3'd3: nd = m_data ^ bus.writedata[7:0];
                    3'd4: if (BLINK) m_mask <= bus.writedata[7:0];
                    3'd5: if (BLINK) begin
                        m_period <= bus.writedata[23:0];
                        m_k0     <= m_edge;
                    end
                    default: ;
                endcase
            end
            m_data <= nd;
            m_edge <= m_edge + 1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_data};
            3'd4:    return BLINK ? {24'h0, m_mask} : 32'h0;
            3'd5:    return BLINK ? {8'h0, m_period} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("cyc_out_port", {24'h0, out_port}, {24'h0, m_data});
            check("cyc_readdata", bus.readdata, exp_read(bus.address));
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(name, bus.readdata, exp);
    endtask

    initial begin
        int r;
        logic [2:0] a;
        logic [31:0] d;

        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Reset state
        check("rst_out_port", {24'h0, out_port}, 32'h5A);
        read_check("rst_rd_data", 3'd0, 32'h5A);
        read_check("rst_rd_mask", 3'd4, 32'h0);
        read_check("rst_rd_period", 3'd5, 32'h0);

        // Atomic write ops on consecutive cycles
        bus_write(3'd0, 32'h0000_00F0);
        check("wr_data", {24'h0, out_port}, 32'hF0);
        bus_write(3'd1, 32'h0000_000F);
        check("wr_set", {24'h0, out_port}, 32'hFF);
        bus_write(3'd2, 32'h0000_0030);
        check("wr_clear", {24'h0, out_port}, 32'hCF);
        bus_write(3'd3, 32'h0000_0081);
        check("wr_toggle", {24'h0, out_port}, 32'h4E);
        read_check("rd_set_zero", 3'd1, 32'h0);

        // Blink with P=4 on bit 0 (inert without the timer)
        bus_write(3'd4, 32'h0000_0001);
        bus_write(3'd5, 32'd4);
        idle(3);
        check("blink_before_tick", {24'h0, out_port}, 32'h4E);
        idle(1);
        check("blink_tick1", {24'h0, out_port}, BLINK ? 32'h4F : 32'h4E);
        idle(4);
        check("blink_tick2", {24'h0, out_port}, 32'h4E);
        idle(3);
        bus_write(3'd1, 32'h0000_0080);
        check("set_on_tick", {24'h0, out_port}, 32'hCE);
        idle(3);
        check("after_drop_pre", {24'h0, out_port}, 32'hCE);
        idle(1);
        check("after_drop_tick", {24'h0, out_port}, BLINK ? 32'hCF : 32'hCE);
        bus_write(3'd5, 32'd0);
        idle(12);
        check("blink_frozen", {24'h0, out_port}, BLINK ? 32'hCF : 32'hCE);
        read_check("rd_period_zero", 3'd5, 32'h0);
        read_check("rd_mask", 3'd4, BLINK ? 32'h1 : 32'h0);

        // Asynchronous reset mid-period
        bus_write(3'd4, 32'h0000_00FF);
        bus_write(3'd5, 32'd3);
        idle(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'h0, out_port}, 32'h5A);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(20);
        check("no_tick_after_rst", {24'h0, out_port}, 32'h5A);
        read_check("rst2_rd_mask", 3'd4, 32'h0);
        read_check("rst2_rd_period", 3'd5, 32'h0);

        // Randomized traffic, one reset pulse midway
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2;
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            r = $urandom_range(0, 99);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd5) d = $urandom_range(0, 6);
            bus.address   = a;
            bus.writedata = d;
            if (r < 45) begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.write_n    = 1'b1;
                if (!bus.chipselect) bus.write_n = 1'($urandom_range(0, 1));
            end else begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        idle(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
